dct_zigzag_buffer: RTL and testbench
====================================

Name: dct_zigzag_buffer

Overview:
- Downstream neighbour of the 2-D DCT core. Consumes the DCT's serial coefficient stream (`y`/`valid`, 64 coefficients per 8x8 block, row-major index order 0..63).
- Reorders each block into JPEG zigzag order through a ping-pong pair of 64-entry banks.
- Presents the result on a valid/ready stream to the quantiser/entropy stage.
- The DCT output cannot be stalled, so this block absorbs downstream backpressure for up to one extra block and flags any overflow.

Parameters:
- DATA_WIDTH, 8, coefficient width; must match the DCT output width.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  coefficient from the DCT (`y`).
- in_valid  input  1  coefficient qualifier (DCT `valid`); no backpressure on this side.
- out_data  output  DATA_WIDTH  coefficient in zigzag order.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_last  output  1  marks the 64th (zigzag position 63) coefficient of a block.
- overflow  output  1  sticky flag: at least one block was dropped.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_last=0, overflow=0, out_data=0; both banks marked empty; wr_cnt=0, rd_cnt=0; wsel=0, rsel=0.
  - Bank contents are not reset.
  - Reset mid-block discards any partial or full blocks.
- Write side:
  - wr_cnt (6 bit) advances on every in_valid cycle and wraps 63->0. Gaps in in_valid are allowed and do not advance it.
  - At block start (in_valid && wr_cnt==0) the block is accepted if full[wsel]==0 (registered flag value). Otherwise the whole block is dropped: drop_blk=1 for those 64 samples, and overflow is set in that cycle and stays set until reset.
  - Dropped samples still advance wr_cnt, so block alignment is preserved.
  - Accepted samples are written to bank[wsel][wr_cnt].
  - When the 64th accepted sample is written: full[wsel] is set at the next edge and wsel toggles.
- Read side:
  - rd_cnt is the zigzag position 0..63. Read address = ZZ[rd_cnt], using the standard JPEG table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
  - Bank read is synchronous, and out_data/out_valid/out_last are registers. A prefetch/skid stage is required so that:
    - out_valid first rises exactly 2 cycles after the cycle in which the 64th sample of a block is written, provided no earlier block is still being drained.
    - With out_ready held high, one coefficient is transferred per cycle.
    - There are zero bubbles between consecutive full blocks.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable. out_valid never drops without a handshake.
  - out_last=1 exactly with zigzag position 63.
  - On the handshake of position 63: full[rsel] clears at the next edge, rsel toggles, and rd_cnt wraps to 0.
- Simultaneous events:
  - If a bank frees (clear of full) in the same cycle a new block starts on that bank, the registered flag is still 1, so the block is dropped. This is deterministic and verified.
  - A write and a read to different banks in the same cycle are independent.
- Capacity: one block draining plus one block filling. A third block arriving while both banks are full is dropped in its entirety.
- Widths: pass-through only; no arithmetic on data.

Test Plan:
- Single block, in_data = index 0..63 on consecutive cycles, out_ready=1 -> out_valid rises 2 cycles after index 63 is written; outputs are 0,1,8,16,9,2,... ending in 63; out_last only on the 64th output; overflow=0.
- Two back-to-back blocks (values 0..63 then 100..163, 128 consecutive in_valid cycles), out_ready=1 -> 128 outputs with no bubble between blocks; second block starts 100,101,108,116; overflow=0.
- Backpressure: one block, out_ready toggling 1,0,0,1,... -> each output held stable while out_ready=0; full sequence correct; exactly 64 handshakes.
- Overflow: out_ready=0, three consecutive blocks -> overflow rises on the first sample of block 3. With out_ready then set to 1, only blocks 1 and 2 are emitted in order; block 3 never appears; overflow stays 1 until rst.
- Gapped input: block with in_valid=1 every third cycle -> output identical to the dense case, and out_valid rises 2 cycles after the 64th valid sample.
- Reset mid-operation: rst asserted for 1 cycle after 30 samples of block 2 while block 1 is half drained -> next cycle out_valid=0 and overflow=0; a fresh block afterwards is emitted correctly from zigzag position 0.

Source files
------------

// File: rtl/dct_zigzag_buffer.sv
// Reorders 8x8 DCT coefficient blocks from row-major into JPEG zigzag order via two ping-pong banks.
// Input is never stalled; a block arriving while both banks are occupied is dropped and flagged.
module dct_zigzag_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overflow
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DATA_WIDTH-1:0] bank0 [64];
  logic [DATA_WIDTH-1:0] bank1 [64];

  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic [5:0]            wr_cnt;
  logic                  wsel;
  logic                  drop_blk;

  logic [5:0]            rd_cnt;
  logic                  rd_sel;
  logic                  rsel;
  logic [DATA_WIDTH-1:0] pf_data;
  logic                  pf_valid;
  logic                  pf_last;

  logic                  blk_start;
  logic                  drop_now;
  logic                  wr_en;
  logic                  wr_done;
  logic                  out_load;
  logic                  pf_free;
  logic                  rd_avail;
  logic                  rd_en;
  logic                  rd_done;
  logic [5:0]            rd_addr;

  always_comb begin
    blk_start = in_valid && (wr_cnt == 6'd0);
    drop_now  = blk_start ? full[wsel] : drop_blk;
    wr_en     = in_valid && !drop_now;
    wr_done   = wr_en && (wr_cnt == 6'd63);
    out_load  = !out_valid || out_ready;
    pf_free   = !pf_valid || out_load;
    // Zigzag position 0 reads address 0, which is already written when the
    // block completes, so the first read can launch in the completion cycle.
    rd_avail  = full[rd_sel] || (wr_done && (wsel == rd_sel));
    rd_en     = rd_avail && pf_free;
    rd_addr   = ZZ[rd_cnt];
    rd_done   = out_valid && out_ready && out_last;
  end

  always_comb begin
    full_nxt = full;
    if (wr_done) begin
      full_nxt[wsel] = 1'b1;
    end
    if (rd_done) begin
      full_nxt[rsel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= 6'd0;
      wsel     <= 1'b0;
      drop_blk <= 1'b0;
      overflow <= 1'b0;
      full     <= 2'b00;
    end else begin
      full <= full_nxt;
      if (in_valid) begin
        wr_cnt   <= wr_cnt + 6'd1;
        drop_blk <= drop_now;
      end
      if (blk_start && drop_now) begin
        overflow <= 1'b1;
      end
      if (wr_done) begin
        wsel <= ~wsel;
      end
    end
  end

  // Bank storage and its synchronous read port carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wsel) begin
        bank1[wr_cnt] <= in_data;
      end else begin
        bank0[wr_cnt] <= in_data;
      end
    end
    if (rd_en) begin
      pf_data <= rd_sel ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= 6'd0;
      rd_sel    <= 1'b0;
      rsel      <= 1'b0;
      pf_valid  <= 1'b0;
      pf_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (pf_free) begin
        pf_valid <= rd_en;
        pf_last  <= rd_en && (rd_cnt == 6'd63);
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63) begin
          rd_sel <= ~rd_sel;
        end
      end
      if (out_load) begin
        out_valid <= pf_valid;
        out_last  <= pf_valid && pf_last;
        if (pf_valid) begin
          out_data <= pf_data;
        end
      end
      if (rd_done) begin
        rsel <= ~rsel;
      end
    end
  end

endmodule

// File: tb/tb_dct_zigzag_buffer.sv
// Bench for dct_zigzag_buffer: block-level reference model (diagonal-walk zigzag, bank occupancy count)
// compared against every handshake, plus latency, hold-under-stall and overflow checks.
module tb_dct_zigzag_buffer;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;

  dct_zigzag_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model, evaluated at negedge for the transaction on the next posedge.
  int            zz_addr [64];
  logic [DW-1:0] expq [$];
  logic [DW-1:0] blk [64];
  int            ncyc = 0;
  int            held = 0;
  int            wpos = 0;
  bit            drop = 1'b0;
  bit            exp_ovf = 1'b0;
  int            out_pos = 0;
  int            n_hs = 0;
  int            last_done_cyc = -100;
  int            rise_cyc = -1;
  bit            prev_valid = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      expq.delete();
      held = 0; wpos = 0; drop = 1'b0; exp_ovf = 1'b0;
      out_pos = 0; stall_prev = 1'b0; prev_valid = 1'b0;
    end else begin
      check("overflow", overflow, exp_ovf);
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, stall_data);
        check("hold_last", out_last, stall_last);
      end
      if (out_valid && !prev_valid) rise_cyc = ncyc;
      prev_valid = out_valid;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (in_valid && wpos == 0) begin
        drop = (held >= 2);
        if (drop) exp_ovf = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("spurious_out", 1, 0);
        else check("out_data", out_data, expq.pop_front());
        check("out_last", out_last, out_pos == 63);
        n_hs++;
        if (out_pos == 63) begin
          out_pos = 0;
          held--;
        end else begin
          out_pos++;
        end
      end
      if (in_valid) begin
        if (!drop) blk[wpos] = in_data;
        if (wpos == 63 && !drop) begin
          for (int k = 0; k < 64; k++) expq.push_back(blk[zz_addr[k]]);
          held++;
          last_done_cyc = ncyc;
        end
        wpos = (wpos + 1) % 64;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap < 0 picks a random gap of 0..3 idle cycles after each sample
  task automatic send_samples(input int base, input int first, input int count, input int gap, input bit rnd);
    for (int i = first; i < first + count; i++) begin
      int g;
      in_valid = 1'b1;
      in_data  = rnd ? DW'($urandom) : DW'(base + i);
      tick();
      in_valid = 1'b0;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) tick();
    end
  endtask

  task automatic send_block(input int base, input int gap, input bit rnd);
    send_samples(base, 0, 64, gap, rnd);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t = 0;
    while ((expq.size() != 0 || out_valid) && t < budget) begin
      tick();
      t++;
    end
    check(tag, t < budget, 1);
  endtask

  int  hs0;
  int  bub;
  bit  send_done;

  initial begin
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int j = 0; j < 8; j++) begin
        int r;
        int c;
        r = (s % 2 == 0) ? 7 - j : j;
        c = s - r;
        if (c >= 0 && c < 8) begin
          zz_addr[k] = r * 8 + c;
          k++;
        end
      end
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // Single dense block, index values
    out_ready = 1'b1;
    hs0 = n_hs;
    send_block(0, 0, 1'b0);
    wait_drain("t1_drain", 300);
    check("t1_latency", rise_cyc - last_done_cyc, 2);
    check("t1_count", n_hs - hs0, 64);
    check("t1_overflow", overflow, 0);

    // Two back-to-back blocks, no bubble between them
    hs0 = n_hs;
    bub = 0;
    fork
      begin
        send_block(0, 0, 1'b0);
        send_block(100, 0, 1'b0);
      end
      begin
        for (int t = 0; t < 400 && !out_valid; t++) tick();
        for (int t = 0; t < 128; t++) begin
          if (out_valid) bub++;
          tick();
        end
      end
    join
    wait_drain("t2_drain", 300);
    check("t2_dense_valid", bub, 128);
    check("t2_count", n_hs - hs0, 128);
    check("t2_overflow", overflow, 0);

    // Backpressure with ready pattern 1,0,0
    hs0 = n_hs;
    fork
      send_block(0, 0, 1'b1);
      begin
        for (int t = 0; t < 2000 && (n_hs - hs0) < 64; t++) begin
          out_ready = (t % 3 == 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("t3_drain", 300);
    check("t3_count", n_hs - hs0, 64);

    // Overflow: three blocks with the sink stalled
    out_ready = 1'b0;
    hs0 = n_hs;
    send_block(0, 0, 1'b1);
    send_block(0, 0, 1'b1);
    check("t4_ovf_before", overflow, 0);
    send_samples(0, 0, 1, 0, 1'b1);
    check("t4_ovf_rise", overflow, 1);
    send_samples(0, 1, 63, 0, 1'b1);
    out_ready = 1'b1;
    wait_drain("t4_drain", 400);
    check("t4_count", n_hs - hs0, 128);
    check("t4_ovf_sticky", overflow, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_ovf_cleared", overflow, 0);

    // Gapped input, one sample every third cycle
    hs0 = n_hs;
    send_block(0, 2, 1'b1);
    wait_drain("t5_drain", 300);
    check("t5_latency", rise_cyc - last_done_cyc, 2);
    check("t5_count", n_hs - hs0, 64);

    // Reset while block 1 drains and block 2 is half written
    out_ready = 1'b0;
    send_block(0, 0, 1'b1);
    out_ready = 1'b1;
    send_samples(0, 0, 30, 0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_overflow", overflow, 0);
    hs0 = n_hs;
    send_block(0, 0, 1'b1);
    wait_drain("t6_drain", 300);
    check("t6_count", n_hs - hs0, 64);

    // Random gaps and random sink readiness
    send_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) send_block(0, -1, 1'b1);
        send_done = 1'b1;
      end
      begin
        for (int t = 0; t < 5000 && !send_done; t++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("t7_drain", 500);
    check("t7_queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
